// File: rtl/priority_gen.sv
`default_nettype none
// ============================================================================
// Module   : priority_gen
// Purpose  : Free-running priority square-wave generator. A cycle counter
//            runs 0..PRIORITY_TIME-1. The registered priority output inverts
//            each time the counter wraps, which gives PRIORITY_TIME cycles
//            low followed by PRIORITY_TIME cycles high.
// Params   : PRIORITY_TIME - clock cycles per priority phase (1 .. 65536)
// Ports    : clk        - clock; all state changes on its rising edge
//            rst        - synchronous active-high reset
//            o_priority - registered square wave. The name is prefixed
//                         because `priority` is a reserved word.
//            o_count    - current counter value (PRIORITY_GEN_STATUS_EN only)
//            o_wrap     - one-cycle pulse in the cycle after each toggle
//                         (PRIORITY_GEN_STATUS_EN only)
// Macro    : PRIORITY_GEN_STATUS_EN - adds the o_count and o_wrap status
//            outputs. Priority timing is the same with or without it.
// Revision : 1.0 - initial release
// ============================================================================
module priority_gen #(
    parameter int  PRIORITY_TIME = 20,
    localparam int CW = ($clog2(PRIORITY_TIME) > 1) ? $clog2(PRIORITY_TIME) : 1
) (
    input  logic          clk,
    input  logic          rst,
`ifdef PRIORITY_GEN_STATUS_EN
    output logic [CW-1:0] o_count,
    output logic          o_wrap,
`endif
    output logic          o_priority
);

    // Terminal count. The counter wraps to zero here and never reaches 2^CW.
    localparam logic [CW-1:0] c_last_cnt = CW'(PRIORITY_TIME - 1);

    if ((PRIORITY_TIME < 1) || (PRIORITY_TIME > 65536)) begin : g_param_check
        $error("priority_gen: PRIORITY_TIME=%0d outside legal range 1..65536",
               PRIORITY_TIME);
    end

    logic [CW-1:0] r_cnt_q;
    logic [CW-1:0] w_cnt_d;
    logic          r_prio_q;
    logic          w_prio_d;
    logic          w_at_last;

    always_comb begin
        w_at_last = (r_cnt_q == c_last_cnt);
        w_cnt_d   = w_at_last ? '0 : (r_cnt_q + CW'(1));
        // The phase flips on the same edge that the counter wraps.
        w_prio_d  = r_prio_q ^ w_at_last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_q  <= '0;
            r_prio_q <= 1'b0;
        end else begin
            r_cnt_q  <= w_cnt_d;
            r_prio_q <= w_prio_d;
        end
    end

    assign o_priority = r_prio_q;

`ifdef PRIORITY_GEN_STATUS_EN
    logic r_wrap_q;
    logic w_wrap_d;

    // The pulse is registered from the same condition that toggles priority.
    // It is therefore high during the first cycle of each new phase.
    always_comb begin
        w_wrap_d = w_at_last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrap_q <= 1'b0;
        end else begin
            r_wrap_q <= w_wrap_d;
        end
    end

    assign o_count = r_cnt_q;
    assign o_wrap  = r_wrap_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_priority_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_priority_gen
// Purpose  : Directed self-checking bench for priority_gen. It instantiates
//            the design with PRIORITY_TIME = 20, 1 and 5. Expected values
//            come from the number of non-reset edges since each instance's
//            last reset:
//              priority = (e / PT) % 2
//              count    = e % PT
//              wrap     = (e > 0) && (e % PT == 0)
// Revision : 1.0 - initial release
// ============================================================================
module tb_priority_gen;

    logic clk;
    logic rst20;
    logic rst1;
    logic rst5;
    logic p20;
    logic p1;
    logic p5;
`ifdef PRIORITY_GEN_STATUS_EN
    logic [4:0] c20;
    logic [0:0] c1;
    logic [2:0] c5;
    logic       w20;
    logic       w1;
    logic       w5;
`endif

    int total;
    int bad;
    int e20;
    int e1;
    int e5;
    int toggles;
    logic prev;

    priority_gen #(.PRIORITY_TIME(20)) u_dut20 (
        .clk        (clk),
        .rst        (rst20),
`ifdef PRIORITY_GEN_STATUS_EN
        .o_count    (c20),
        .o_wrap     (w20),
`endif
        .o_priority (p20)
    );

    priority_gen #(.PRIORITY_TIME(1)) u_dut1 (
        .clk        (clk),
        .rst        (rst1),
`ifdef PRIORITY_GEN_STATUS_EN
        .o_count    (c1),
        .o_wrap     (w1),
`endif
        .o_priority (p1)
    );

    priority_gen #(.PRIORITY_TIME(5)) u_dut5 (
        .clk        (clk),
        .rst        (rst5),
`ifdef PRIORITY_GEN_STATUS_EN
        .o_count    (c5),
        .o_wrap     (w5),
`endif
        .o_priority (p5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Compare every instance against the values expected for its edge count.
    task automatic check_all();
        chk("prio20", 32'(p20), 32'((e20 / 20) % 2));
        chk("prio1",  32'(p1),  32'(e1 % 2));
        chk("prio5",  32'(p5),  32'((e5 / 5) % 2));
`ifdef PRIORITY_GEN_STATUS_EN
        chk("cnt20",  32'(c20), 32'(e20 % 20));
        chk("wrap20", 32'(w20), 32'((e20 > 0) && (e20 % 20 == 0)));
        chk("cnt1",   32'(c1),  32'd0);
        chk("wrap1",  32'(w1),  32'(e1 > 0));
        chk("cnt5",   32'(c5),  32'(e5 % 5));
        chk("wrap5",  32'(w5),  32'((e5 > 0) && (e5 % 5 == 0)));
        chk("cnt5_range", 32'(c5 < 3'd5), 32'd1);
`endif
    endtask

    // Advance one rising edge, then check on the following falling edge.
    // Reset values are sampled here, before the rising edge.
    task automatic advance();
        e20 = rst20 ? 0 : e20 + 1;
        e1  = rst1  ? 0 : e1 + 1;
        e5  = rst5  ? 0 : e5 + 1;
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        e20   = 0;
        e1    = 0;
        e5    = 0;
        rst20 = 1'b1;
        rst1  = 1'b1;
        rst5  = 1'b1;
        @(negedge clk);

        // Reset held for three edges.
        repeat (3) advance();

        // Release all resets. Rises are expected at 20, 60 and falls at 40, 80.
        rst20   = 1'b0;
        rst1    = 1'b0;
        rst5    = 1'b0;
        toggles = 0;
        repeat (80) begin
            prev = p20;
            advance();
            if (p20 !== prev) toggles++;
        end
        chk("toggles20_in_80", 32'(toggles), 32'd4);

        // Run to count = 7 in a high phase (e20 = 107).
        repeat (27) advance();
        chk("mid_prio_high", 32'(p20), 32'd1);

        // Reset mid-phase for one edge. A full 20-cycle low phase must follow.
        rst20 = 1'b1;
        advance();
        rst20 = 1'b0;
        repeat (20) advance();

        // Restart, run to count = 19 in a low phase, then reset on the wrap edge.
        rst20 = 1'b1;
        advance();
        rst20 = 1'b0;
        repeat (19) advance();
        rst20 = 1'b1;
        advance();
        chk("rst_at_wrap_prio", 32'(p20), 32'd0);
        rst20 = 1'b0;
        repeat (21) advance();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/priority_gen.md
PRIORITY_GEN -- requirements
Module: priority_gen

Interface
REQ-001 The block SHALL have parameter PRIORITY_TIME, default 20, meaning clock cycles per priority phase (legal range 1 to 2^16).
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit, SHALL be the reset: synchronous, active-high.
REQ-004 Port priority, output, 1 bit, SHALL be the registered priority square wave.
REQ-005 The internal counter width CW SHALL be max(1, ceil(log2(PRIORITY_TIME))) bits.

Function
REQ-006 The block SHALL hold an internal cycle counter, range 0..PRIORITY_TIME-1.
REQ-007 On each rising clk edge with rst=0 and counter < PRIORITY_TIME-1, the counter SHALL increment by 1 and priority SHALL hold.
REQ-008 On each rising clk edge with rst=0 and counter = PRIORITY_TIME-1, the counter SHALL wrap to 0 and priority SHALL invert in the same cycle.
REQ-009 priority SHALL therefore be a 50% duty square wave, period 2*PRIORITY_TIME cycles: PRIORITY_TIME cycles low, then PRIORITY_TIME cycles high.
REQ-010 The first 0->1 transition SHALL occur on the PRIORITY_TIME-th rising edge after the first edge sampling rst=0.
REQ-011 For PRIORITY_TIME=1, priority SHALL toggle on every rising edge with rst=0.
REQ-012 priority SHALL be driven directly from a flip-flop: no combinational path from any input, glitch-free.
REQ-013 The counter SHALL never exceed PRIORITY_TIME-1 and SHALL never wrap through its 2^CW limit.
REQ-014 The block SHALL have no enable or hold input; counting is free-running whenever rst=0.
REQ-015 A PRIORITY_TIME value below 1 SHALL cause an elaboration-time error, reported by a $error or $fatal in an initial/generate block.

Reset
REQ-016 While rst=1 at a rising edge, the counter SHALL load 0 and priority SHALL load 0.
REQ-017 rst SHALL take precedence over counting and wrap on the same edge, including when the counter equals PRIORITY_TIME-1.
REQ-018 A reset asserted mid-phase SHALL discard the partial count; after release, a full PRIORITY_TIME low phase SHALL follow.
REQ-019 Before the first reset edge, outputs are unspecified; the bench SHALL apply rst for at least one edge.

Configuration
REQ-020 Macro PRIORITY_GEN_STATUS_EN, when defined, SHALL add output count, CW bits, carrying the current counter value.
REQ-021 The same macro SHALL also add output wrap, 1 bit: a registered pulse high for exactly one cycle following each edge at which priority toggled. wrap resets to 0.
REQ-022 Without PRIORITY_GEN_STATUS_EN, count and wrap SHALL be absent, and priority timing SHALL be identical to the defined case.

Verification
REQ-023 Reset hold: PRIORITY_TIME=20, rst=1 for 3 edges -> priority=0 and counter=0 throughout; with the macro, count=0 and wrap=0.
REQ-024 Basic toggle: PRIORITY_TIME=20, 10 ns clk, rst released after 1 edge -> priority rises on the 20th edge with rst=0, falls on the 40th, rises on the 60th, falls on the 80th; 4 toggles in 800 ns.
REQ-025 Mid-phase reset: rst=1 for one edge when counter=7 and priority=1 -> next cycle priority=0 and counter=0; next rise exactly 20 edges after rst drops.
REQ-026 Reset at wrap: rst=1 on the edge where counter=19 -> priority=0 and counter=0; no toggle and no wrap pulse.
REQ-027 Minimum parameter: PRIORITY_TIME=1 -> priority toggles every edge after reset release (0,1,0,1...); with the macro, count stays 0 and wrap is high every cycle after the first toggle.
REQ-028 Non-power-of-two: PRIORITY_TIME=5 -> count sequence 0,1,2,3,4,0 and priority period 10 cycles; count never reaches 5..7.
